c7bexu_ecl: RTL and testbench
=============================

// Module: c7bexu_ecl
// PURPOSE
//  Execution control logic for the c7bexu core. It produces the front-end
//  stall (stall_ifu) and the M/W pipeline-register hold (stall_reg_mw).
//  It tracks in-flight CSR ops through E/M/W and LSU ops from issue
//  (E stage) to completion or exception (LS1/LS3).
//  Sits between the LSU/CSR units and the IFU/pipeline registers.
// PARAMETERS
//  none (stage depths are fixed constants in c7bexu_pkg)
// PORTS
//  clk                    in   1  core clock, all state on rising edge
//  resetn                 in   1  reset, asynchronous, active-low
//  stall_ifu              out  1  hold fetch/decode (no new issue)
//  stall_reg_mw           out  1  hold M/W pipeline registers
//  lsu_vld_e              in   1  load/store issued in E this cycle
//  lsu_except_ale_ls1     in   1  address-alignment exception, LS1 (ends op)
//  lsu_except_buserr_ls3  in   1  bus error, LS3 (ends op)
//  lsu_except_ecc_ls3     in   1  ECC error, LS3 (ends op; see CONFIGURATION)
//  lsu_data_valid_ls3     in   1  load data returned, LS3 (ends op)
//  lsu_wr_fin_ls3         in   1  store write finished, LS3 (ends op)
//  csr_vld_e              in   1  CSR instruction in E this cycle
// BEHAVIOUR
//  - Registers: csr_vld_m, csr_vld_w, lsu_busy. All reset to 0 asynchronously.
//  - CSR pipeline: on each edge, csr_vld_m <= csr_vld_e and csr_vld_w <= csr_vld_m.
//  - csr_stall = csr_vld_e | csr_vld_m | csr_vld_w. This is the E cycle plus
//    2 cycles after it. A back-to-back CSR extends the stall.
//  - lsu_end = ale_ls1 | buserr_ls3 | ecc_ls3 (if enabled) | data_valid_ls3
//    | wr_fin_ls3.
//  - lsu_busy next-state:
//      lsu_vld_e -> 1 (set wins over a simultaneous lsu_end);
//      else lsu_end -> 0;
//      else hold.
//  - lsu_end while lsu_busy==0 and !lsu_vld_e: ignored, no state change.
//  - stall_ifu = csr_stall | lsu_vld_e | lsu_busy. Combinational, asserted in
//    the same cycle as the request. Drops in the cycle after the lsu_end edge.
//  - stall_reg_mw = lsu_busy & ~lsu_end. M/W registers are held while an LSU
//    op waits for a result. They are released in the cycle its result or
//    exception arrives.
//  - Reset mid-operation clears every tracker. Both outputs are 0 while
//    resetn is low and in the first cycle after release.
//  - Idle (all inputs 0): both outputs 0.
//  - Single outstanding LSU op only. lsu_vld_e while busy re-arms busy.
// CONFIGURATION
//  - C7BEXU_ECL_ECC_EN defined: lsu_except_ecc_ls3 is part of lsu_end.
//  - Not defined: the port still exists but is ignored. An ECC error then
//    does not end the LSU stall; data_valid/wr_fin must follow.
// STRUCTURE
//  - c7bexu_pkg holds the end-cause bit indices (ALE, BUSERR, ECC, DVLD,
//    WRFIN) and the CSR stall depth constant (2).
//  - One sub-module, c7bexu_ecl_lsu_trk: holds the lsu_busy set/clear flop and
//    computes lsu_end.
//  - The top level holds the CSR shift chain and the output OR logic.
// TESTING
//  - Idle after reset, all inputs 0 for 2 cycles -> stall_ifu=0, stall_reg_mw=0.
//  - csr_vld_e=1 for 1 cycle -> stall_ifu=1 in that cycle and the next 2, then 0.
//  - lsu_vld_e=1 for 1 cycle, no end -> stall_ifu=1 and stays 1;
//    stall_reg_mw=1 from the next cycle.
//  - lsu_vld_e pulse, then lsu_except_ale_ls1=1 for 1 cycle -> stall_reg_mw=0
//    that cycle; stall_ifu=0 one cycle later.
//  - lsu_vld_e pulse, then lsu_data_valid_ls3 pulse (repeat with
//    lsu_wr_fin_ls3 and buserr) -> stall_ifu=0 the cycle after the pulse.
//  - lsu_except_ecc_ls3 pulse while busy -> stall_ifu clears with
//    C7BEXU_ECL_ECC_EN defined; stays 1 without it.
//  - Assert resetn=0 while busy -> both outputs 0 immediately.

Source files
------------

// File: rtl/c7bexu_pkg.sv
// Shared constants for the c7bexu execution control logic: LSU end-cause bit
// positions and the number of cycles a CSR op keeps fetch stalled after E.
package c7bexu_pkg;

  localparam int END_ALE    = 0;
  localparam int END_BUSERR = 1;
  localparam int END_ECC    = 2;
  localparam int END_DVLD   = 3;
  localparam int END_WRFIN  = 4;
  localparam int END_W      = 5;

  localparam int CSR_STALL_DEPTH = 2;

  typedef logic [END_W-1:0] lsu_end_vec_t;

endpackage

// File: rtl/c7bexu_ecl_lsu_trk.sv
// Single-outstanding LSU op tracker: busy from issue in E until an end cause.
// Build option C7BEXU_ECL_ECC_EN makes an ECC error one of the end causes.
module c7bexu_ecl_lsu_trk
  import c7bexu_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  input  logic         lsu_vld_e,
  input  lsu_end_vec_t end_vec,
  output logic         lsu_busy,
  output logic         lsu_end
);

`ifdef C7BEXU_ECL_ECC_EN
  localparam lsu_end_vec_t END_MASK = '1;
`else
  // Without ECC support an ECC error is not terminal; data/write-finish must follow.
  localparam lsu_end_vec_t END_MASK = ~(lsu_end_vec_t'(1) << END_ECC);
`endif

  assign lsu_end = |(end_vec & END_MASK);

  // A new issue wins over a same-cycle end, so a re-issue keeps the op tracked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      lsu_busy <= 1'b0;
    else if (lsu_vld_e)
      lsu_busy <= 1'b1;
    else if (lsu_end)
      lsu_busy <= 1'b0;
  end

endmodule

// File: rtl/c7bexu_ecl.sv
// c7bexu execution control: front-end stall and M/W register hold derived
// from in-flight CSR ops and the LSU tracker. Option: C7BEXU_ECL_ECC_EN.
module c7bexu_ecl
  import c7bexu_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  output logic stall_ifu,
  output logic stall_reg_mw,
  input  logic lsu_vld_e,
  input  logic lsu_except_ale_ls1,
  input  logic lsu_except_buserr_ls3,
  input  logic lsu_except_ecc_ls3,
  input  logic lsu_data_valid_ls3,
  input  logic lsu_wr_fin_ls3,
  input  logic csr_vld_e
);

  // csr_sr[0] is the CSR op in M, csr_sr[CSR_STALL_DEPTH-1] the one in W.
  logic [CSR_STALL_DEPTH-1:0] csr_sr;
  logic                       csr_stall;
  logic                       lsu_busy;
  logic                       lsu_end;
  lsu_end_vec_t               end_vec;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      csr_sr <= '0;
    else
      csr_sr <= {csr_sr[CSR_STALL_DEPTH-2:0], csr_vld_e};
  end

  assign csr_stall = csr_vld_e | (|csr_sr);

  always_comb begin
    end_vec             = '0;
    end_vec[END_ALE]    = lsu_except_ale_ls1;
    end_vec[END_BUSERR] = lsu_except_buserr_ls3;
    end_vec[END_ECC]    = lsu_except_ecc_ls3;
    end_vec[END_DVLD]   = lsu_data_valid_ls3;
    end_vec[END_WRFIN]  = lsu_wr_fin_ls3;
  end

  c7bexu_ecl_lsu_trk u_lsu_trk (
    .clk       (clk),
    .resetn    (resetn),
    .lsu_vld_e (lsu_vld_e),
    .end_vec   (end_vec),
    .lsu_busy  (lsu_busy),
    .lsu_end   (lsu_end)
  );

  // Outputs are forced low during reset even if requests are already asserted.
  assign stall_ifu    = resetn & (csr_stall | lsu_vld_e | lsu_busy);
  assign stall_reg_mw = resetn & lsu_busy & ~lsu_end;

endmodule

// File: tb/tb_c7bexu_ecl.sv
// Scoreboard bench for c7bexu_ecl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the stall rules.
module tb_c7bexu_ecl;

  logic clk = 1'b0;
  logic resetn;
  logic stall_ifu, stall_reg_mw;
  logic lsu_vld_e, ale, buserr, ecc, dvld, wrfin, csr_vld_e;

  always #5 clk = ~clk;

  c7bexu_ecl dut (
    .clk                   (clk),
    .resetn                (resetn),
    .stall_ifu             (stall_ifu),
    .stall_reg_mw          (stall_reg_mw),
    .lsu_vld_e             (lsu_vld_e),
    .lsu_except_ale_ls1    (ale),
    .lsu_except_buserr_ls3 (buserr),
    .lsu_except_ecc_ls3    (ecc),
    .lsu_data_valid_ls3    (dvld),
    .lsu_wr_fin_ls3        (wrfin),
    .csr_vld_e             (csr_vld_e)
  );

`ifdef C7BEXU_ECL_ECC_EN
  localparam bit ECC_ENDS = 1'b1;
`else
  localparam bit ECC_ENDS = 1'b0;
`endif

  typedef struct packed {
    logic ifu;
    logic mw;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: cycles of CSR stall left after E, and whether an LSU op is open.
  int   m_csr_left = 0;
  bit   m_busy     = 1'b0;

  // Bit order of a stimulus word: {csr, wrfin, dvld, ecc, buserr, ale, vld}.
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] VLD  = 7'b0000001;
  localparam logic [6:0] ALE  = 7'b0000010;
  localparam logic [6:0] BUS  = 7'b0000100;
  localparam logic [6:0] ECC  = 7'b0001000;
  localparam logic [6:0] DV   = 7'b0010000;
  localparam logic [6:0] WF   = 7'b0100000;
  localparam logic [6:0] CSR  = 7'b1000000;

  task automatic apply(input logic [6:0] v);
    {csr_vld_e, wrfin, dvld, ecc, buserr, ale, lsu_vld_e} = v;
  endtask

  task automatic step(input logic [6:0] v);
    bit   done;
    exp_t e;
    @(posedge clk);
    #1;
    apply(v);
    done  = v[1] | v[2] | (ECC_ENDS & v[3]) | v[4] | v[5];
    e.ifu = v[6] | (m_csr_left > 0) | v[0] | m_busy;
    e.mw  = m_busy & ~done;
    exp_q.push_back(e);
    m_csr_left = v[6] ? 2 : (m_csr_left > 0 ? m_csr_left - 1 : 0);
    if (v[0])      m_busy = 1'b1;
    else if (done) m_busy = 1'b0;
  endtask

  task automatic reset_cycle(input logic [6:0] v);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    apply(v);
    exp_q.push_back(exp_t'(2'b00));
    m_csr_left = 0;
    m_busy     = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    apply(IDLE);
    exp_q.push_back(exp_t'(2'b00));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (stall_ifu !== e.ifu) begin
          n_fail++;
          $display("FAIL stall_ifu cycle %0d: got %b expected %b", cyc_no, stall_ifu, e.ifu);
        end
        n_tests++;
        if (stall_reg_mw !== e.mw) begin
          n_fail++;
          $display("FAIL stall_reg_mw cycle %0d: got %b expected %b", cyc_no, stall_reg_mw, e.mw);
        end
      end
    end
  end

  initial begin : driver
    logic [6:0] v;
    int         guard;
    resetn = 1'b0;
    apply(IDLE);
    reset_cycle(IDLE);
    reset_cycle(CSR | VLD);
    release_reset();
    step(IDLE); step(IDLE);

    // CSR pulse: stall in E and the following two cycles; then back-to-back CSRs.
    step(CSR); repeat (4) step(IDLE);
    step(CSR); step(CSR); repeat (4) step(IDLE);

    // LSU issue without an end stays stalled; then an alignment exception.
    step(VLD); repeat (4) step(IDLE);
    step(ALE); repeat (2) step(IDLE);

    // Each LS3 completion cause.
    step(VLD); step(IDLE); step(DV);  repeat (2) step(IDLE);
    step(VLD); step(IDLE); step(WF);  repeat (2) step(IDLE);
    step(VLD); step(IDLE); step(BUS); repeat (2) step(IDLE);

    // ECC error while busy: terminal only with the ECC option.
    step(VLD); step(IDLE); step(ECC); repeat (2) step(IDLE);
    step(DV); step(IDLE);

    // Stray end while idle, issue coinciding with an end, re-issue while busy.
    step(DV | WF); step(IDLE);
    step(VLD | DV); step(IDLE); step(VLD); step(IDLE); step(WF); step(IDLE);

    // Reset while busy with requests still asserted.
    step(VLD); step(IDLE);
    reset_cycle(VLD | CSR);
    release_reset();
    step(IDLE);

    for (int i = 0; i < 2500; i++) begin
      v = '0;
      v[0] = ($urandom_range(0, 7) == 0);
      v[1] = ($urandom_range(0, 15) == 0);
      v[2] = ($urandom_range(0, 15) == 0);
      v[3] = ($urandom_range(0, 7) == 0);
      v[4] = ($urandom_range(0, 9) == 0);
      v[5] = ($urandom_range(0, 9) == 0);
      v[6] = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 199) == 0) begin
        reset_cycle(v);
        release_reset();
      end else begin
        step(v);
      end
    end
    step(IDLE);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
